// File: rtl/sipo_collector.sv
// sipo_collector
//   Serial-in/parallel-out collector that sits downstream of the piso serializer.
//   Qualified serial bits are shifted into a WIDTH-bit register. Each completed
//   word is presented on a one-entry valid/ready output register. When a word
//   completes while the output register is full and out_ready is low, that word
//   is dropped and the sticky overrun flag is set.
//
//   Ports
//     clock         in   rising-edge clock
//     reset         in   synchronous, active-high; clears all state
//     serial_in     in   serial data bit
//     serial_valid  in   serial_in is sampled only when this is 1
//     align         in   restarts word alignment and discards the partial word
//     parallel_out  out  assembled word; held stable while out_valid=1
//     out_valid     out  parallel_out holds an undelivered word
//     out_ready     in   the consumer takes the word when out_valid & out_ready
//     overrun       out  sticky flag: a completed word was dropped
//     bit_count     out  number of bits collected in the current partial word
module sipo_collector #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             align,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);

  localparam logic [0:0]    ST_EMPTY = 1'b0;
  localparam logic [0:0]    ST_FULL  = 1'b1;
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] full_word;
  logic             word_done;
  logic [0:0]       state;

  // Shifts one bit into a word in the configured bit order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                input logic             b);
    if (MSB_FIRST)
      return {s[WIDTH-2:0], b};
    else
      return {b, s[WIDTH-1:1]};
  endfunction

  // The completed word includes the bit arriving on this edge, so the output
  // register can load it on the same edge with no added latency.
  assign full_word = shift_in(sh, serial_in);
  // An align cycle never completes a word, even when bit_count is at its last value.
  assign word_done = serial_valid && !align && (bit_count == LAST);
  assign out_valid = (state == ST_FULL);

  // Shift register and bit counter
  always_ff @(posedge clock) begin
    if (reset) begin
      sh        <= '0;
      bit_count <= '0;
    end else if (align) begin
      // A bit that arrives with align becomes the first bit of the new word.
      sh        <= serial_valid ? shift_in('0, serial_in) : '0;
      bit_count <= serial_valid ? CW'(1) : '0;
    end else if (serial_valid) begin
      sh        <= full_word;
      bit_count <= word_done ? '0 : bit_count + CW'(1);
    end
  end

  // Output register
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_EMPTY;
      parallel_out <= '0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (word_done) begin
            parallel_out <= full_word;
            state        <= ST_FULL;
          end
        end
        default: begin
          if (word_done) begin
            // A same-cycle handoff replaces the word. Without out_ready the new
            // word is lost and the old word is kept.
            if (out_ready)
              parallel_out <= full_word;
            else
              overrun <= 1'b1;
          end else if (out_ready) begin
            state <= ST_EMPTY;
          end
        end
      endcase
    end
  end

endmodule
